// File: rtl/mod241_residue_accumulator.sv
// Serial mod-241 accumulator: sums NUM_TERMS partial residues per frame and
// emits one fully reduced residue (0..240) over a valid/ready output stream.
module mod241_residue_accumulator #(
    parameter int NUM_TERMS = 50,
    parameter int CNT_W     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_range_err
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TERMS - 1);

    logic [0:0]       state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_err_q, out_err_d;

    logic       accept;
    logic       out_fire;
    logic [8:0] sum;
    logic [7:0] acc_next;
    logic       err_next;

    assign in_ready  = rst_n && (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Both operands are at most 255, so at most two subtractions of 241 suffice.
    assign sum      = {1'b0, acc_q} + {1'b0, in_data};
    assign err_next = err_q || (in_data >= 8'd241);

    always_comb begin
        acc_next = sum[7:0];
        if (sum >= 9'd482) begin
            acc_next = 8'(sum - 9'd482);
        end else if (sum >= 9'd241) begin
            acc_next = 8'(sum - 9'd241);
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        if (clr) begin
            state_d = ST_ACCUM;
            acc_d   = 8'd0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else if (state_q == ST_ACCUM) begin
            if (accept) begin
                if (cnt_q == LAST_IDX) begin
                    state_d    = ST_DONE;
                    out_data_d = acc_next;
                    out_err_d  = err_next;
                    acc_d      = 8'd0;
                    cnt_d      = '0;
                    err_d      = 1'b0;
                end else begin
                    acc_d = acc_next;
                    cnt_d = cnt_q + 1'b1;
                    err_d = err_next;
                end
            end
        end else if (out_fire) begin
            state_d = ST_ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACCUM;
            acc_q      <= 8'd0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            out_data_q <= 8'd0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    assign out_data      = out_data_q;
    assign out_range_err = out_err_q;

    a_out_in_range: assert property (@(posedge clk) disable iff (!rst_n) out_data <= 8'd240)
        else $error("out_data exceeded 240");

endmodule

// File: tb/tb_mod241_residue_accumulator.sv
// Directed bench for mod241_residue_accumulator with NUM_TERMS=4 and
// hand-computed expected residues.
module tb_mod241_residue_accumulator;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_range_err;

    int tests_run = 0;
    int tests_failed = 0;

    mod241_residue_accumulator #(
        .NUM_TERMS(4),
        .CNT_W    (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_range_err(out_range_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, obs);
        end
    endtask

    // Present one term on the next falling edge and let the rising edge take it.
    task automatic send_term(input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        send_term(a);
        send_term(b);
        send_term(c);
        send_term(d);
    endtask

    // Wait (bounded) for out_valid, check the result, then complete the handshake.
    task automatic get_result(input string tag, input logic [7:0] exp_data, input logic exp_err);
        int waited;
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_data"}, 32'(out_data), 32'(exp_data));
        check_val({tag, "_err"}, 32'(out_range_err), 32'(exp_err));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check_val({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;

        #12;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data", 32'(out_data), 32'd0);
        check_val("rst_out_err", 32'(out_range_err), 32'd0);
        check_val("rst_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_in_ready_high", 32'(in_ready), 32'd1);

        // 240 x 4 = 960 = 3*241 + 237, in_valid held across all four terms
        send_term(8'd240);
        send_term(8'd240);
        send_term(8'd240);
        @(negedge clk);
        check_val("lat_before_last", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'd240;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_val("lat_one_cycle", 32'(out_valid), 32'd1);
        check_val("lat_in_ready_low", 32'(in_ready), 32'd0);
        get_result("f240", 8'd237, 1'b0);

        // 255 x 4 = 1020 = 4*241 + 56, out-of-range terms flagged
        send_frame(8'd255, 8'd255, 8'd255, 8'd255);
        get_result("f255", 8'd56, 1'b1);

        // Exact multiple of 241, then a clean frame proving err was cleared
        send_frame(8'd100, 8'd141, 8'd0, 8'd0);
        get_result("fzero", 8'd0, 1'b0);
        send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        get_result("f1234", 8'd10, 1'b0);

        // Backpressure: result held for 20 cycles while input pulses are refused
        send_frame(8'd5, 8'd6, 8'd7, 8'd8);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            in_data  = 8'd200;
            check_val($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
            check_val($sformatf("bp_data_%0d", i), 32'(out_data), 32'd26);
            check_val($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
        end
        get_result("fbp", 8'd26, 1'b0);
        // If any refused pulse had been taken, this frame would be misaligned.
        send_frame(8'd1, 8'd1, 8'd1, 8'd1);
        get_result("fafterbp", 8'd4, 1'b0);

        // Sparse input, then clr (with a colliding valid term) discards the partial frame
        send_term(8'd50);
        idle(3);
        send_term(8'd60);
        idle(2);
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd99;
        @(posedge clk);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        check_val("clr_out_valid", 32'(out_valid), 32'd0);
        check_val("clr_in_ready", 32'(in_ready), 32'd1);
        send_frame(8'd7, 8'd8, 8'd9, 8'd10);
        get_result("fclr", 8'd34, 1'b0);

        // Asynchronous reset mid-frame loses the two accepted terms
        send_term(8'd3);
        send_term(8'd3);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("mrst_out_valid", 32'(out_valid), 32'd0);
        check_val("mrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("mrst_in_ready_rel", 32'(in_ready), 32'd1);
        send_frame(8'd1, 8'd1, 8'd1, 8'd1);
        get_result("fmrst", 8'd4, 1'b0);

        // Asynchronous reset while a result is pending drops it immediately
        send_frame(8'd9, 8'd9, 8'd9, 8'd9);
        @(negedge clk);
        in_valid = 1'b0;
        check_val("drst_pending", 32'(out_valid), 32'd1);
        check_val("drst_pending_data", 32'(out_data), 32'd36);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("drst_out_valid", 32'(out_valid), 32'd0);
        check_val("drst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("drst_no_result", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
